// File: rtl/clock_cfg_sched.sv
// Clock-generator configuration sequencer: round-robin between two requesters,
// reset/lock/retry handshake with the generator. Define CLK_RELOCK_EN to relock on loss of lock.
module clock_cfg_sched #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned LOCK_STABLE  = 4,
  parameter int unsigned MAX_RETRY    = 3,
  parameter logic [2:0]  LOCK_CODE    = 3'b100
) (
  input  logic        ref_clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [31:0] req_counter_0,
  input  logic [31:0] req_counter_1,
  input  logic [31:0] req_ref_0,
  input  logic [31:0] req_ref_1,
  input  logic [8:0]  req_init_0,
  input  logic [8:0]  req_init_1,
  input  logic [2:0]  status,
  output logic [1:0]  done,
  output logic        fail,
  output logic        clk_resetn,
  output logic [31:0] counter,
  output logic [31:0] ref_counter,
  output logic [8:0]  init,
  output logic        busy,
  output logic        locked
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] APPLY     = 2'd1;
  localparam logic [1:0] WAIT_LOCK = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;

  localparam int unsigned RW = (RST_CYCLES   > 1) ? $clog2(RST_CYCLES)   : 1;
  localparam int unsigned TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int unsigned SW = (LOCK_STABLE  > 1) ? $clog2(LOCK_STABLE)  : 1;
  localparam int unsigned YW = (MAX_RETRY    > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [1:0]    state;
  logic          cur_id;
  logic          last_id;
  logic          relock;
  logic [1:0]    pend;
  logic [RW-1:0] rst_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [SW-1:0] stab_cnt;
  logic [YW-1:0] retry_cnt;

  logic [1:0] req_eff;
  logic       win_id;
  logic       lock_now;
  logic       stab_hit;
  logic       tmo_hit;
  logic       retry_ok;
  logic       fin;
  logic       go_relock;
  logic       go_req;

  assign busy = (state != IDLE);

  // A requester whose done pulsed last cycle may still be holding req; mask it once.
  always_comb begin
    req_eff   = req & ~pend;
    win_id    = 1'b0;
    if (req_eff == 2'b11) win_id = ~last_id;
    else                  win_id = req_eff[1];
    lock_now  = (status == LOCK_CODE);
    stab_hit  = lock_now && (stab_cnt == SW'(LOCK_STABLE - 1));
    tmo_hit   = (tmo_cnt == TW'(LOCK_TIMEOUT - 1));
    retry_ok  = (retry_cnt < YW'(MAX_RETRY));
    fin       = stab_hit || (tmo_hit && !retry_ok);
    go_relock = 1'b0;
`ifdef CLK_RELOCK_EN
    go_relock = locked && !lock_now;
`endif
    go_req    = !go_relock && (|req_eff);
  end

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state       <= IDLE;
      clk_resetn  <= 1'b0;
      counter     <= '0;
      ref_counter <= '0;
      init        <= '0;
      done        <= '0;
      fail        <= 1'b0;
      locked      <= 1'b0;
      cur_id      <= 1'b0;
      last_id     <= 1'b1;
      relock      <= 1'b0;
      pend        <= '0;
      rst_cnt     <= '0;
      tmo_cnt     <= '0;
      stab_cnt    <= '0;
      retry_cnt   <= '0;
    end else begin
      done <= '0;
      fail <= 1'b0;
      pend <= '0;
      case (state)
        IDLE: begin
          if (go_relock || go_req) begin
            state      <= APPLY;
            clk_resetn <= 1'b0;
            rst_cnt    <= '0;
            retry_cnt  <= '0;
            locked     <= 1'b0;
            relock     <= go_relock;
            if (go_req) begin
              cur_id      <= win_id;
              counter     <= win_id ? req_counter_1 : req_counter_0;
              ref_counter <= win_id ? req_ref_1     : req_ref_0;
              init        <= win_id ? req_init_1    : req_init_0;
            end
          end else if (!lock_now) begin
            locked <= 1'b0;
          end
        end
        APPLY: begin
          if (rst_cnt == RW'(RST_CYCLES - 1)) begin
            state      <= WAIT_LOCK;
            clk_resetn <= 1'b1;
            tmo_cnt    <= '0;
            stab_cnt   <= '0;
          end else begin
            rst_cnt <= (rst_cnt == '1) ? rst_cnt : rst_cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          // Lock seen on the final timeout cycle still counts as success.
          if (fin) begin
            state  <= DONE;
            locked <= stab_hit;
            if (!relock) begin
              done    <= cur_id ? 2'b10 : 2'b01;
              fail    <= !stab_hit;
              last_id <= cur_id;
            end
          end else if (tmo_hit) begin
            retry_cnt  <= retry_cnt + 1'b1;
            state      <= APPLY;
            clk_resetn <= 1'b0;
            rst_cnt    <= '0;
          end else begin
            stab_cnt <= lock_now ? ((stab_cnt == '1) ? stab_cnt : stab_cnt + 1'b1) : '0;
            tmo_cnt  <= (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          pend   <= done;
          relock <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_cfg_sched.sv
// Self-checking bench for clock_cfg_sched: vector table driving a done-ordered
// scoreboard, plus loss-of-lock and mid-sequence reset sequences.
module tb_clock_cfg_sched;
  localparam int unsigned RST_CYC = 16;
  localparam int unsigned TMO     = 100;
  localparam int unsigned STABLE  = 4;
  localparam int unsigned RETRY   = 3;
  localparam logic [2:0]  LCODE   = 3'b100;

  logic        ref_clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [31:0] req_counter_0, req_counter_1, req_ref_0, req_ref_1;
  logic [8:0]  req_init_0, req_init_1;
  logic [2:0]  status;
  logic [1:0]  done;
  logic        fail, clk_resetn, busy, locked;
  logic [31:0] counter, ref_counter;
  logic [8:0]  init;

  clock_cfg_sched #(
    .RST_CYCLES(RST_CYC), .LOCK_TIMEOUT(TMO), .LOCK_STABLE(STABLE),
    .MAX_RETRY(RETRY), .LOCK_CODE(LCODE)
  ) dut (
    .ref_clk(ref_clk), .reset(reset), .req(req),
    .req_counter_0(req_counter_0), .req_counter_1(req_counter_1),
    .req_ref_0(req_ref_0), .req_ref_1(req_ref_1),
    .req_init_0(req_init_0), .req_init_1(req_init_1),
    .status(status), .done(done), .fail(fail), .clk_resetn(clk_resetn),
    .counter(counter), .ref_counter(ref_counter), .init(init),
    .busy(busy), .locked(locked)
  );

  always #5 ref_clk = ~ref_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // mode 0: lock from WAIT_LOCK entry, 1: never lock, 2: drop every 3rd cycle
  typedef struct {
    logic [1:0]  mask;
    logic [31:0] c0, r0; logic [8:0] i0;
    logic [31:0] c1, r1; logic [8:0] i1;
    int          mode;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] c, r; logic [8:0] i;
    logic        fail;
    int          applies;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  logic model_last;

  function automatic logic [2:0] stat_for(int mode, logic b, logic rn, int cyc);
    if (!b) return LCODE;
    if (!rn || mode == 1) return 3'b000;
    if (mode == 2 && (cyc % 3) == 2) return 3'b000;
    return LCODE;
  endfunction

  function automatic exp_t mk_exp(vec_t v, logic id);
    exp_t e;
    e.id      = id;
    e.c       = id ? v.c1 : v.c0;
    e.r       = id ? v.r1 : v.r0;
    e.i       = id ? v.i1 : v.i0;
    e.fail    = (v.mode != 0);
    e.applies = (v.mode != 0) ? int'(RETRY) + 1 : 1;
    return e;
  endfunction

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   runs = 0, run_len = 0, bad_run = 0, bad_cfg = 0, rise_cyc = 0, cyc = 0;
    logic low, prev_low = 1'b0;
    req_counter_0 = v.c0; req_ref_0 = v.r0; req_init_0 = v.i0;
    req_counter_1 = v.c1; req_ref_1 = v.r1; req_init_1 = v.i1;
    if (v.mask == 2'b11) begin
      sb.push_back(mk_exp(v, ~model_last));
      sb.push_back(mk_exp(v, model_last));
    end else begin
      sb.push_back(mk_exp(v, v.mask[1]));
    end
    req = v.mask;
    for (int k = 0; k < 3000 && sb.size() > 0; k++) begin
      @(negedge ref_clk);
      cyc++;
      status = stat_for(v.mode, busy, clk_resetn, cyc);
      low = busy && !clk_resetn;
      if (low) begin
        if (!prev_low) begin runs++; run_len = 0; end
        run_len++;
        if (counter !== sb[0].c || ref_counter !== sb[0].r || init !== sb[0].i) bad_cfg++;
      end else if (prev_low) begin
        if (run_len != int'(RST_CYC)) bad_run++;
        rise_cyc = cyc;
      end
      prev_low = low;
      if (done != 2'b00) begin
        e = sb.pop_front();
        check("done_bits", done, e.id ? 2'b10 : 2'b01);
        check("fail", fail, e.fail);
        check("locked", locked, !e.fail);
        check("apply_phases", runs, e.applies);
        check("resetn_low_len_errors", bad_run, 0);
        check("cfg_during_apply_errors", bad_cfg, 0);
        check("counter", counter, e.c);
        check("ref_counter", ref_counter, e.r);
        check("init", init, e.i);
        if (!e.fail) check("lock_latency", cyc - rise_cyc, STABLE);
        req[e.id]  = 1'b0;
        model_last = e.id;
        runs = 0; bad_run = 0; bad_cfg = 0;
      end
    end
    if (sb.size() != 0) begin
      check("done_wait_timeout", sb.size(), 0);
      sb.delete();
      req = 2'b00;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int ndone;
    logic [31:0] last_cnt;
    vecs[0] = '{2'b11, 32'd8000, 32'd10, 9'd20, 32'd4321, 32'd99, 9'd7, 0};
    vecs[1] = '{2'b01, 32'd8000, 32'd10, 9'd20, 32'd1, 32'd1, 9'd1, 0};
    vecs[2] = '{2'b10, 32'd5, 32'd5, 9'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9'h1FF, 1};
    vecs[3] = '{2'b01, 32'd55, 32'd66, 9'd77, 32'd0, 32'd0, 9'd0, 2};
    vecs[4] = '{2'b11, 32'hA5A5_0001, 32'd3, 9'd100, 32'h0F0F_0002, 32'd4, 9'd200, 0};
    vecs[5] = '{2'b10, 32'd0, 32'd0, 9'd0, 32'h1234_5678, 32'd42, 9'd300, 0};

    reset = 1'b1; req = 2'b00; status = 3'b000;
    req_counter_0 = '0; req_counter_1 = '0; req_ref_0 = '0; req_ref_1 = '0;
    req_init_0 = '0; req_init_1 = '0;
    model_last = 1'b1;
    repeat (3) @(negedge ref_clk);
    check("rst_clk_resetn", clk_resetn, 1'b0);
    check("rst_counter", counter, 32'd0);
    check("rst_ref_counter", ref_counter, 32'd0);
    check("rst_init", init, 9'd0);
    check("rst_done", done, 2'b00);
    check("rst_fail", fail, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_locked", locked, 1'b0);
    reset = 1'b0;

    foreach (vecs[n]) run_vec(vecs[n]);

    // Loss of lock while idle
    last_cnt = vecs[5].c1;
    repeat (2) @(negedge ref_clk);
    check("idle_locked_held", locked, 1'b1);
    status = 3'b000;
    @(negedge ref_clk);
`ifdef CLK_RELOCK_EN
    check("relock_busy", busy, 1'b1);
    check("relock_locked_cleared", locked, 1'b0);
    check("relock_resetn", clk_resetn, 1'b0);
    check("relock_counter", counter, last_cnt);
    ndone = 0;
    for (int k = 0; k < 300 && !(locked && !busy); k++) begin
      status = clk_resetn ? LCODE : 3'b000;
      @(negedge ref_clk);
      if (done != 2'b00) ndone++;
    end
    check("relock_locked", locked, 1'b1);
    check("relock_idle", busy, 1'b0);
    check("relock_done_pulses", ndone, 0);
`else
    check("loss_locked_cleared", locked, 1'b0);
    ndone = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge ref_clk);
      if (busy) ndone++;
    end
    check("loss_no_sequence", ndone, 0);
    check("loss_counter_kept", counter, last_cnt);
`endif

    // Reset in the middle of WAIT_LOCK
    status = 3'b000;
    req_counter_0 = 32'd777; req_ref_0 = 32'd8; req_init_0 = 9'd9;
    req = 2'b01;
    ndone = 0;
    for (int k = 0; k < 200 && !(busy && clk_resetn); k++) begin
      @(negedge ref_clk);
      if (done != 2'b00) ndone++;
    end
    check("reached_wait_lock", busy && clk_resetn, 1'b1);
    repeat (5) begin
      @(negedge ref_clk);
      if (done != 2'b00) ndone++;
    end
    reset = 1'b1; req = 2'b00;
    @(negedge ref_clk);
    if (done != 2'b00) ndone++;
    check("mid_rst_clk_resetn", clk_resetn, 1'b0);
    check("mid_rst_counter", counter, 32'd0);
    check("mid_rst_ref_counter", ref_counter, 32'd0);
    check("mid_rst_init", init, 9'd0);
    check("mid_rst_fail", fail, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_locked", locked, 1'b0);
    reset = 1'b0;
    status = LCODE;
    repeat (5) begin
      @(negedge ref_clk);
      if (done != 2'b00) ndone++;
    end
    check("mid_rst_no_done", ndone, 0);
    check("post_rst_resetn_low", clk_resetn, 1'b0);
    check("post_rst_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
